// File: rtl/esc_pkg.sv
// Purpose : shared defaults and elaboration-time parameter check for the ESC PWM bank.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
package esc_pkg;

  localparam int unsigned ESC_PERIOD_W  = 20;     // 2**20 clks ~ 21ms @ 50MHz
  localparam int unsigned ESC_MIN_PULSE = 50000;  // 1ms @ 50MHz
  localparam int unsigned ESC_SCALE     = 3;

  // True when the widest pulse still fits inside one frame and the slew step is non-zero.
  // Evaluated at 64 bits so the check itself cannot overflow.
  function automatic bit esc_params_ok(input int unsigned spd_w,
                                       input int unsigned period_w,
                                       input int unsigned min_pulse,
                                       input int unsigned scale,
                                       input int unsigned slew);
    longint unsigned max_pulse;
    longint unsigned frame_len;
    max_pulse = 64'(min_pulse) + (((64'd1 << spd_w) - 64'd1) * 64'(scale));
    frame_len = 64'd1 << period_w;
    return (slew != 0) && (max_pulse < frame_len);
  endfunction

endpackage

// File: rtl/esc_slew_ch.sv
// Purpose : one motor channel - target/applied speed registers, slew step, compare value, pulse output.
// Latency : pwm is registered, 1 clk behind cnt; new compare value takes effect from the next frame.
// Backpr. : none; wrt is accepted every clk except while motors_off is high.
//
// Ports: clk/rst (async active-high); cnt = shared frame counter; frame_upd = cnt is all-ones;
//        armed, motors_off, wrt = shared controls; spd = this channel's speed word;
//        pwm = pulse output; at_tgt = applied speed equals target.
module esc_slew_ch
  import esc_pkg::*;
#(
  parameter int unsigned SPD_W     = 11,
  parameter int unsigned PERIOD_W  = ESC_PERIOD_W,
  parameter int unsigned MIN_PULSE = ESC_MIN_PULSE,
  parameter int unsigned SCALE     = ESC_SCALE,
  parameter int unsigned SLEW      = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PERIOD_W-1:0] cnt,
  input  logic                frame_upd,
  input  logic                armed,
  input  logic                motors_off,
  input  logic                wrt,
  input  logic [SPD_W-1:0]    spd,
  output logic                pwm,
  output logic                at_tgt
);

  localparam logic [PERIOD_W-1:0] MIN_CMP  = PERIOD_W'(MIN_PULSE);
  localparam int unsigned         CUR_MAX  = (2 ** SPD_W) - 1;
  // A slew larger than the speed range behaves exactly like the full range.
  localparam int unsigned         SLEW_LIM = (SLEW > CUR_MAX) ? CUR_MAX : SLEW;
  localparam logic [SPD_W:0]      SLEW_V   = (SPD_W + 1)'(SLEW_LIM);

  logic [SPD_W-1:0]    tgt;
  logic [SPD_W-1:0]    cur;
  logic [PERIOD_W-1:0] cmp;

  logic [SPD_W:0]      sdiff;      // tgt - cur, two's complement at SPD_W+1 bits
  logic [SPD_W:0]      mag;
  logic [SPD_W:0]      step;
  logic [SPD_W:0]      cur_nxt_w;
  logic [PERIOD_W-1:0] cmp_nxt;

  always_comb begin
    sdiff     = {1'b0, tgt} - {1'b0, cur};
    mag       = sdiff[SPD_W] ? (~sdiff + 1'b1) : sdiff;
    step      = (mag > SLEW_V) ? SLEW_V : mag;
    // step never exceeds |tgt-cur|, so the result stays within 0..CUR_MAX.
    cur_nxt_w = sdiff[SPD_W] ? ({1'b0, cur} - step) : ({1'b0, cur} + step);
    cmp_nxt   = MIN_CMP + PERIOD_W'(cur_nxt_w) * PERIOD_W'(SCALE);
  end

  assign at_tgt = (sdiff == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt <= '0;
      cur <= '0;
      cmp <= MIN_CMP;
      pwm <= 1'b0;
    end else begin
      // motors_off bypasses the registered compare so a long pulse is cut on the very next clk.
      pwm <= (cnt < (motors_off ? MIN_CMP : cmp));
      if (motors_off) begin
        tgt <= '0;
        cur <= '0;
        cmp <= MIN_CMP;
      end else begin
        // The frame update reads tgt before this edge, so a coincident wrt lands one frame later.
        if (wrt) begin
          tgt <= spd;
        end
        if (frame_upd) begin
          if (!armed) begin
            cur <= '0;
            cmp <= MIN_CMP;
          end else begin
            cur <= cur_nxt_w[SPD_W-1:0];
            cmp <= cmp_nxt;
          end
        end
      end
    end
  end

endmodule

// File: rtl/esc_bank.sv
// Purpose : N-channel ESC PWM generator with slew limiting, arming hold-off and frame-synchronous updates.
// Latency : pwm 1 clk behind the frame counter; a written speed starts slewing at the next frame boundary.
// Backpr. : none; wrt is a fire-and-forget strobe, ignored while motors_off is high.
//
// Ports: clk, rst (async active-high); spd = packed speeds, ch i at spd[i*SPD_W +: SPD_W];
//        wrt = capture spd into targets; motors_off = force idle; pwm = per-channel pulses;
//        armed = arming hold-off complete; frame_tick = last clk of frame; at_tgt = all channels settled.
module esc_bank
  import esc_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned SPD_W      = 11,
  parameter int unsigned PERIOD_W   = ESC_PERIOD_W,
  parameter int unsigned MIN_PULSE  = ESC_MIN_PULSE,
  parameter int unsigned SCALE      = ESC_SCALE,
  parameter int unsigned SLEW       = 64,
  parameter int unsigned ARM_FRAMES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*SPD_W-1:0]  spd,
  input  logic                   wrt,
  input  logic                   motors_off,
  output logic [N_CH-1:0]        pwm,
  output logic                   armed,
  output logic                   frame_tick,
  output logic                   at_tgt
);

  if (!esc_params_ok(SPD_W, PERIOD_W, MIN_PULSE, SCALE, SLEW)) begin : g_bad_params
    $error("esc_bank: max pulse does not fit in the frame, or SLEW is zero");
  end

  localparam int unsigned        ARM_W   = (ARM_FRAMES < 1) ? 1 : $clog2(ARM_FRAMES + 1);
  localparam logic [ARM_W-1:0]   ARM_END = ARM_W'(ARM_FRAMES);

  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] cnt_nxt;
  logic                frame_upd;
  logic [ARM_W-1:0]    arm_cnt;
  logic [N_CH-1:0]     ch_at_tgt;

  assign cnt_nxt   = cnt + 1'b1;
  assign frame_upd = &cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      frame_tick <= 1'b0;
      arm_cnt    <= '0;
      armed      <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      // Registered from the next count so the tick lines up with cnt == all-ones.
      frame_tick <= &cnt_nxt;
      if (frame_upd && (arm_cnt != ARM_END)) begin
        arm_cnt <= arm_cnt + 1'b1;
        if ((arm_cnt + 1'b1) == ARM_END) begin
          armed <= 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    esc_slew_ch #(
      .SPD_W     (SPD_W),
      .PERIOD_W  (PERIOD_W),
      .MIN_PULSE (MIN_PULSE),
      .SCALE     (SCALE),
      .SLEW      (SLEW)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .cnt        (cnt),
      .frame_upd  (frame_upd),
      .armed      (armed),
      .motors_off (motors_off),
      .wrt        (wrt),
      .spd        (spd[i*SPD_W +: SPD_W]),
      .pwm        (pwm[i]),
      .at_tgt     (ch_at_tgt[i])
    );
  end

  assign at_tgt = &ch_at_tgt;

endmodule

// File: tb/tb_esc_bank.sv
// Purpose : self-checking bench for esc_bank; frame-level reference model feeds a scoreboard.
// Latency : n/a.
// Backpr. : n/a.
module tb_esc_bank;

  localparam int N_CH       = 4;
  localparam int SPD_W      = 6;
  localparam int PERIOD_W   = 8;
  localparam int MIN_PULSE  = 64;
  localparam int SCALE      = 1;
  localparam int SLEW       = 8;
  localparam int ARM_FRAMES = 2;
  localparam int FRAME      = 256;
  localparam int N_DIR      = 24;
  localparam int N_RAND     = 20;
  localparam int N_FRAMES   = N_DIR + N_RAND;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [N_CH*SPD_W-1:0] spd = '0;
  logic                  wrt = 1'b0;
  logic                  motors_off = 1'b0;
  logic [N_CH-1:0]       pwm;
  logic                  armed;
  logic                  frame_tick;
  logic                  at_tgt;

  esc_bank #(
    .N_CH       (N_CH),
    .SPD_W      (SPD_W),
    .PERIOD_W   (PERIOD_W),
    .MIN_PULSE  (MIN_PULSE),
    .SCALE      (SCALE),
    .SLEW       (SLEW),
    .ARM_FRAMES (ARM_FRAMES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .spd        (spd),
    .wrt        (wrt),
    .motors_off (motors_off),
    .pwm        (pwm),
    .armed      (armed),
    .frame_tick (frame_tick),
    .at_tgt     (at_tgt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N_CH-1:0][15:0] width;
    logic                  armed;
    logic                  at_tgt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mon_frames = 0;
  bit   mon_en = 1'b0;

  // Reference model state: speeds as plain integers.
  int m_tgt[N_CH];
  int m_cur[N_CH];
  int m_upd;
  bit m_armed;

  // Per-frame plan: wrt position/values, motors_off on/off positions (-1 = none).
  int a_wp, a_on, a_off;
  int a_spd[N_CH];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic set_plan(input int f);
    a_wp = -1; a_on = -1; a_off = -1;
    for (int c = 0; c < N_CH; c++) a_spd[c] = m_tgt[c];
    case (f)
      1:  begin a_wp = 100; a_spd[0] = 40; end
      7:  a_on = 90;
      8:  a_off = 50;
      10: begin a_wp = 30; a_spd[0] = 40; a_spd[1] = 63; end
      15: begin a_wp = 5; a_spd[0] = 0; end
      21: begin a_wp = 255; a_spd[2] = 16; end
      default: begin
        if (f >= N_DIR) begin
          if ($urandom_range(0, 1) == 1) begin
            a_wp = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
            for (int c = 0; c < N_CH; c++) a_spd[c] = int'($urandom_range(0, 63));
          end
          if (motors_off) a_off = int'($urandom_range(0, 255));
          else if ($urandom_range(0, 7) == 0) a_on = int'($urandom_range(0, 255));
        end
      end
    endcase
  endtask

  // Monitor: accumulate pulse widths per frame, frame end located via frame_tick.
  initial begin
    int   acc[N_CH];
    bit   tick_prev;
    exp_t e;
    tick_prev = 1'b0;
    for (int c = 0; c < N_CH; c++) acc[c] = 0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (!mon_en) break;
      for (int c = 0; c < N_CH; c++) acc[c] += int'(pwm[c]);
      if (tick_prev) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected frame=%0d no expected entry queued", mon_frames);
        end else begin
          e = sb_q.pop_front();
          for (int c = 0; c < N_CH; c++)
            check($sformatf("width_f%0d_ch%0d", mon_frames, c), acc[c], int'(e.width[c]));
          check($sformatf("armed_f%0d", mon_frames), int'(armed), int'(e.armed));
          check($sformatf("at_tgt_f%0d", mon_frames), int'(at_tgt), int'(e.at_tgt));
        end
        for (int c = 0; c < N_CH; c++) acc[c] = 0;
        mon_frames++;
      end
      tick_prev = frame_tick;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w[N_CH];
    bit   mo_frame;
    bit   all_eq;
    int   d;
    exp_t e;

    for (int c = 0; c < N_CH; c++) begin m_tgt[c] = 0; m_cur[c] = 0; end
    m_upd = 0; m_armed = 1'b0;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pwm", int'(pwm), 0);
    check("rst_armed", int'(armed), 0);
    check("rst_frame_tick", int'(frame_tick), 0);
    check("rst_at_tgt", int'(at_tgt), 1);

    rst = 1'b0;
    mon_en = 1'b1;

    for (int f = 0; f < N_FRAMES; f++) begin
      set_plan(f);
      for (int c = 0; c < N_CH; c++) begin
        w[c] = MIN_PULSE + m_cur[c] * SCALE;
        e.width[c] = '0;
      end
      mo_frame = 1'b0;
      for (int p = 0; p < FRAME; p++) begin
        if (p == a_on)  motors_off = 1'b1;
        if (p == a_off) motors_off = 1'b0;
        wrt = (p == a_wp);
        if (wrt) begin
          for (int c = 0; c < N_CH; c++) spd[c*SPD_W +: SPD_W] = SPD_W'(a_spd[c]);
        end else begin
          spd = (N_CH*SPD_W)'($urandom);
        end
        @(posedge clk);
        // Model the edge at which the counter held p.
        mo_frame = mo_frame | motors_off;
        for (int c = 0; c < N_CH; c++)
          if (p < (mo_frame ? MIN_PULSE : w[c])) e.width[c] = e.width[c] + 16'd1;
        if (p == FRAME - 1) begin
          for (int c = 0; c < N_CH; c++) begin
            if (!m_armed) m_cur[c] = 0;
            else begin
              d = m_tgt[c] - m_cur[c];
              if (d > SLEW) d = SLEW;
              if (d < -SLEW) d = -SLEW;
              m_cur[c] = m_cur[c] + d;
            end
          end
          m_upd++;
        end
        if (motors_off) begin
          for (int c = 0; c < N_CH; c++) begin m_tgt[c] = 0; m_cur[c] = 0; end
        end else if (wrt) begin
          for (int c = 0; c < N_CH; c++) m_tgt[c] = a_spd[c];
        end
        if (p == FRAME - 1) begin
          if (m_upd >= ARM_FRAMES) m_armed = 1'b1;
          all_eq = 1'b1;
          for (int c = 0; c < N_CH; c++) if (m_cur[c] != m_tgt[c]) all_eq = 1'b0;
          e.armed  = m_armed;
          e.at_tgt = all_eq;
          sb_q.push_back(e);
        end
        @(negedge clk);
      end
    end

    wrt = 1'b0;
    @(posedge clk);
    mon_en = 1'b0;
    #2;
    // Counter just passed 0, so every channel is inside its minimum pulse.
    check("pwm_pre_rst", int'(pwm), (1 << N_CH) - 1);
    rst = 1'b1;
    #1;
    check("midpulse_rst_pwm", int'(pwm), 0);
    check("midpulse_rst_armed", int'(armed), 0);
    check("midpulse_rst_frame_tick", int'(frame_tick), 0);
    check("midpulse_rst_at_tgt", int'(at_tgt), 1);
    check("sb_drained", sb_q.size(), 0);
    check("frames_seen", mon_frames, N_FRAMES);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
